// File: rtl/bin_to_bcd8_if.sv
// Purpose: start/busy/done handshake and result bus of the binary-to-BCD converter.
// Latency: none, wires only.
// Backpressure: none; the requester must wait for busy=0 before a new start is taken.
interface bin_to_bcd8_if #(
    parameter int BIN_W = 27
);
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [15:0]      digits_A;
    logic [15:0]      digits_B;
    logic             overflow;

    modport master (
        output start, bin_in,
        input  busy, done, digits_A, digits_B, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, digits_A, digits_B, overflow
    );
endinterface

// File: rtl/bin_to_bcd8.sv
// Purpose: sequential double-dabble, unsigned BIN_W-bit count -> eight BCD digits.
// Latency: done is high BIN_W+1 clock edges after start is driven (edge that samples start counts as the first).
// Backpressure: start is taken only in IDLE; a start while busy (SHIFT or DONE) is dropped.
// Option: `define BCD_SATURATE_EN to clamp values above 99,999,999 to all nines and flag overflow.
module bin_to_bcd8 #(
    parameter int BIN_W = 27
) (
    input  logic          clk,
    input  logic          rst,
    bin_to_bcd8_if.slave  bus
);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [BIN_W-1:0]   shf_q;
    logic [31:0]        bcd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        dig_a_q;
    logic [15:0]        dig_b_q;
    logic [31:0]        bcd_adj;
    logic [BIN_W+31:0]  cat_shl;
    logic [31:0]        bcd_nxt;
    logic [BIN_W-1:0]   shf_nxt;
    logic               last_shift;
`ifdef BCD_SATURATE_EN
    logic               ovf_q;
    logic               ovf_out_q;
`endif

    // Add-3 correction on every nibble at once, then one joint left shift of {bcd, shift}.
    always_comb begin
        bcd_adj = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
        cat_shl = {bcd_adj, shf_q} << 1;
        bcd_nxt = cat_shl[BIN_W+31:BIN_W];
        shf_nxt = cat_shl[BIN_W-1:0];
    end

    assign last_shift = (state == SHIFT) && (cnt_q == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath: load on accepted start, one shift per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shf_q <= '0;
            bcd_q <= 32'h0;
            cnt_q <= '0;
`ifdef BCD_SATURATE_EN
            ovf_q <= 1'b0;
`endif
        end else if (state == IDLE && bus.start) begin
            shf_q <= bus.bin_in;
            bcd_q <= 32'h0;
            cnt_q <= CNT_W'(BIN_W);
`ifdef BCD_SATURATE_EN
            ovf_q <= (32'(bus.bin_in) > 32'd99_999_999);
`endif
        end else if (state == SHIFT) begin
            shf_q <= shf_nxt;
            bcd_q <= bcd_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Result registers are written with the final shifted value on the edge that
    // enters DONE, so they are valid for the whole done cycle and never show partials.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_a_q <= 16'h0;
            dig_b_q <= 16'h0;
`ifdef BCD_SATURATE_EN
            ovf_out_q <= 1'b0;
`endif
        end else if (last_shift) begin
`ifdef BCD_SATURATE_EN
            if (ovf_q) begin
                dig_a_q   <= 16'h9999;
                dig_b_q   <= 16'h9999;
                ovf_out_q <= 1'b1;
            end else begin
                dig_a_q   <= bcd_nxt[15:0];
                dig_b_q   <= bcd_nxt[31:16];
                ovf_out_q <= 1'b0;
            end
`else
            dig_a_q <= bcd_nxt[15:0];
            dig_b_q <= bcd_nxt[31:16];
`endif
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.digits_A = dig_a_q;
    assign bus.digits_B = dig_b_q;
`ifdef BCD_SATURATE_EN
    assign bus.overflow = ovf_out_q;
`else
    assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_bin_to_bcd8.sv
module tb_bin_to_bcd8;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    bin_to_bcd8_if #(.BIN_W(27)) bus ();

    bin_to_bcd8 #(.BIN_W(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start pulse, scramble bin_in afterwards, return edge count until done.
    task automatic run(input logic [26:0] v, output int lat, output logic busy1);
        @(negedge clk);
        bus.bin_in = v;
        bus.start  = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        busy1      = bus.busy;
        bus.start  = 1'b0;
        bus.bin_in = ~v;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    int   lat;
    logic busy1;
    int   done_seen;

    initial begin
        n_chk      = 0;
        n_pass     = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dig",  {bus.digits_B, bus.digits_A}, 32'h0);
        check("rst_ovf",  32'(bus.overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: typical value, latency and busy.
        run(27'd12345678, lat, busy1);
        check("t1_busy", 32'(busy1), 32'd1);
        check("t1_lat",  32'(lat), 32'd28);
        check("t1_a",    32'(bus.digits_A), 32'h5678);
        check("t1_b",    32'(bus.digits_B), 32'h1234);
        check("t1_ovf",  32'(bus.overflow), 32'd0);

        // 2: zero, done pulse width, busy falls after done.
        run(27'd0, lat, busy1);
        check("t2_lat",  32'(lat), 32'd28);
        check("t2_dig",  {bus.digits_B, bus.digits_A}, 32'h0);
        check("t2_busy_done", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t2_done_w", 32'(bus.done), 32'd0);
        check("t2_busy_fall", 32'(bus.busy), 32'd0);
        check("t2_hold", {bus.digits_B, bus.digits_A}, 32'h0);

        // 3: largest representable value.
        run(27'd99999999, lat, busy1);
        check("t3_dig", {bus.digits_B, bus.digits_A}, 32'h9999_9999);
        check("t3_ovf", 32'(bus.overflow), 32'd0);

        // 4: full-scale input, beyond eight digits.
        run(27'd134217727, lat, busy1);
`ifdef BCD_SATURATE_EN
        check("t4_dig", {bus.digits_B, bus.digits_A}, 32'h9999_9999);
        check("t4_ovf", 32'(bus.overflow), 32'd1);
`else
        check("t4_dig", {bus.digits_B, bus.digits_A}, 32'h3421_7727);
        check("t4_ovf", 32'(bus.overflow), 32'd0);
`endif

        // 5: starts while busy are dropped; back-to-back start on first IDLE cycle.
        @(negedge clk);
        bus.bin_in = 27'd12345678;
        bus.start  = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.done && lat < 100) begin
            if (lat == 5) begin
                bus.start  = 1'b1;
                bus.bin_in = 27'd42;
            end else begin
                bus.start  = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("t5_lat", 32'(lat), 32'd28);
        check("t5_first", {bus.digits_B, bus.digits_A}, 32'h1234_5678);
        bus.start  = 1'b1;
        bus.bin_in = 27'd42;
        @(posedge clk);
        @(negedge clk);
        check("t5_done_ign", 32'(bus.busy), 32'd0);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_b2b_busy", 32'(bus.busy), 32'd1);
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("t5_b2b_lat", 32'(lat), 32'd28);
        check("t5_b2b_dig", {bus.digits_B, bus.digits_A}, 32'h0000_0042);

        // 6: reset in the middle of a conversion aborts it.
        @(negedge clk);
        bus.bin_in = 27'd87654321;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_dig",  {bus.digits_B, bus.digits_A}, 32'h0);
        check("t6_ovf",  32'(bus.overflow), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen++;
        end
        check("t6_no_done", 32'(done_seen), 32'd0);
        run(27'd12345678, lat, busy1);
        check("t6_lat", 32'(lat), 32'd28);
        check("t6_after", {bus.digits_B, bus.digits_A}, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
